route_buffer: RTL and testbench
===============================

ROUTE_BUFFER -- requirements
Module: route_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the per-channel queue depth (power of two, >=2).
REQ-003 Ports SHALL be exactly as listed in REQ-004 to REQ-015.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 data_in  input  WIDTH  word to route.
REQ-007 sel  input  1  target channel: 0 selects channel 0, 1 selects channel 1.
REQ-008 en  input  1  write request for data_in to channel sel.
REQ-009 ack0, ack1  input  1 each  consumer pops head word of channel 0/1.
REQ-010 clr_err  input  1  synchronous clear of err.
REQ-011 data_out0, data_out1  output  WIDTH each  head word of channel 0/1.
REQ-012 valid0, valid1  output  1 each  channel 0/1 holds >=1 word.
REQ-013 busy0, busy1  output  1 each  channel 0/1 holds DEPTH words.
REQ-014 err  output  1  sticky flag: a write was dropped.
REQ-015 wr_cnt  output  8  count of accepted writes.

Function
REQ-016 Each channel SHALL be an independent DEPTH-entry FIFO with its own read pointer, write pointer and occupancy count (0..DEPTH).
REQ-017 A write SHALL be accepted on a clock edge when en=1 and the selected channel's occupancy is below DEPTH, evaluated on pre-edge state.
REQ-018 An accepted write SHALL store data_in at the tail of channel sel; the other channel SHALL be unaffected.
REQ-019 A write to a full channel SHALL be dropped, leaving FIFO contents unchanged and setting err at that edge.
REQ-020 Simultaneous write and ack to a full channel SHALL pop the head and drop the write, setting err.
REQ-021 A pop SHALL occur on a clock edge when ackN=1 and validN=1; ackN with validN=0 SHALL be ignored.
REQ-022 A simultaneous accepted write and pop on the same channel SHALL leave occupancy unchanged and advance both pointers.
REQ-023 With occupancy 1, a simultaneous write and pop SHALL make the new word the head, visible on data_outN in the next cycle.
REQ-024 Latency from an accepted write into an empty channel to validN=1 with the word on data_outN SHALL be one clock.
REQ-025 data_outN SHALL always present the entry at the read pointer; its value while validN=0 is don't-care.
REQ-026 validN SHALL equal (occupancy != 0); busyN SHALL equal (occupancy == DEPTH); both SHALL be derived from registered state only.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-028 wr_cnt SHALL increment by 1 per accepted write, wrapping 255 -> 0; dropped writes SHALL NOT count.
REQ-029 clr_err=1 SHALL clear err at the edge; if a drop occurs in the same cycle, err SHALL be 1 (set wins).
REQ-030 Writes and pops on different channels in the same cycle SHALL both take effect.

Reset
REQ-031 While rst_n=0, all occupancy counts, pointers, err and wr_cnt SHALL be 0, independent of clk.
REQ-032 Reset values SHALL be: valid0=valid1=0, busy0=busy1=0, err=0, wr_cnt=0; data_out0=data_out1=0.
REQ-033 Storage contents SHALL be cleared to 0 by reset.
REQ-034 Assertion of rst_n mid-operation SHALL discard all queued words immediately; no write or pop SHALL complete on the edge during which rst_n=0.
REQ-035 The first accepted write SHALL occur at the first rising edge with rst_n=1 and en=1.

Verification
REQ-036 Write 0x1234 to sel=0, then 0xABCD to sel=1 -> next cycle valid0=1 with data_out0=0x1234, and valid1=1 with data_out1=0xABCD; wr_cnt=2.
REQ-037 Write 0x0001, 0x0002 and 0x0003 to channel 0 with no ack -> after the second write busy0=1; the third write is dropped, err=1, wr_cnt=2, and data_out0=0x0001.
REQ-038 Channel 0 holding {0x0001}; assert en (sel=0, data 0x0005) and ack0 together -> valid0=1, data_out0=0x0005, occupancy 1.
REQ-039 Issue 256 accepted writes with continuous ack -> wr_cnt returns to 0, err=0, and every word appears in order.
REQ-040 Channel 1 full; pull rst_n low between edges -> valid1=0, busy1=0, err=0, wr_cnt=0 immediately without a clock edge.
REQ-041 With err=1, assert clr_err together with a drop -> err stays 1; assert clr_err alone next cycle -> err=0.

Source files
------------

// File: rtl/route_buffer.sv
// Two-channel router: each word on data_in is queued into one of two independent FIFOs.
// Writes to a full channel are dropped and latch a sticky error flag.
module route_buffer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             sel,
    input  logic             en,
    input  logic             ack0,
    input  logic             ack1,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic             valid0,
    output logic             valid1,
    output logic             busy0,
    output logic             busy1,
    output logic             err,
    output logic [7:0]       wr_cnt
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q    [2][DEPTH];
    logic [PW-1:0]    rd_ptr_q [2];
    logic [PW-1:0]    wr_ptr_q [2];
    logic [CW-1:0]    cnt_q    [2];
    logic             err_q;
    logic [7:0]       wr_cnt_q;

    logic [1:0] ack;
    logic [1:0] full;
    logic [1:0] push;
    logic [1:0] pop;
    logic       drop;

    // Acceptance is decided on pre-edge occupancy, so a pop in the same cycle
    // does not make room for a write to a full channel.
    always_comb begin
        ack  = {ack1, ack0};
        full = '0;
        push = '0;
        pop  = '0;
        for (int c = 0; c < 2; c++) begin
            full[c] = (cnt_q[c] == FullCnt);
            push[c] = en && (int'(sel) == c) && !full[c];
            pop[c]  = ack[c] && (cnt_q[c] != '0);
        end
        drop = en && full[sel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[c][i] <= '0;
                end
                rd_ptr_q[c] <= '0;
                wr_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c]) begin
                    mem_q[c][wr_ptr_q[c]] <= data_in;
                    wr_ptr_q[c]           <= wr_ptr_q[c] + PW'(1);
                end
                if (pop[c]) begin
                    rd_ptr_q[c] <= rd_ptr_q[c] + PW'(1);
                end
                if (push[c] && !pop[c]) begin
                    cnt_q[c] <= cnt_q[c] + CW'(1);
                end else if (pop[c] && !push[c]) begin
                    cnt_q[c] <= cnt_q[c] - CW'(1);
                end
            end
        end
    end

    // A drop in the same cycle as clr_err leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q    <= 1'b0;
            wr_cnt_q <= 8'd0;
        end else begin
            err_q <= drop | (err_q & ~clr_err);
            if (|push) begin
                wr_cnt_q <= wr_cnt_q + 8'd1;
            end
        end
    end

    assign data_out0 = mem_q[0][rd_ptr_q[0]];
    assign data_out1 = mem_q[1][rd_ptr_q[1]];
    assign valid0    = (cnt_q[0] != '0);
    assign valid1    = (cnt_q[1] != '0);
    assign busy0     = full[0];
    assign busy1     = full[1];
    assign err       = err_q;
    assign wr_cnt    = wr_cnt_q;

endmodule

// File: tb/tb_route_buffer.sv
// Directed self-checking bench for route_buffer (WIDTH=16, DEPTH=2).
module tb_route_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic        sel = 1'b0;
    logic        en = 1'b0;
    logic        ack0 = 1'b0;
    logic        ack1 = 1'b0;
    logic        clr_err = 1'b0;
    logic [15:0] data_out0;
    logic [15:0] data_out1;
    logic        valid0;
    logic        valid1;
    logic        busy0;
    logic        busy1;
    logic        err;
    logic [7:0]  wr_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    route_buffer #(
        .WIDTH(16),
        .DEPTH(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .sel       (sel),
        .en        (en),
        .ack0      (ack0),
        .ack1      (ack1),
        .clr_err   (clr_err),
        .data_out0 (data_out0),
        .data_out1 (data_out1),
        .valid0    (valid0),
        .valid1    (valid1),
        .busy0     (busy0),
        .busy1     (busy1),
        .err       (err),
        .wr_cnt    (wr_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en      = 1'b0;
        ack0    = 1'b0;
        ack1    = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        data_in = 16'hFFFF;
        rst_n   = 1'b0;
        tick();
        checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid0: got %b expected 0", valid0); end
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid1: got %b expected 0", valid1); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0: got %b expected 0", busy0); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b expected 0", busy1); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (wr_cnt !== 8'd0) begin errors++; $display("FAIL reset_wr_cnt: got %0d expected 0", wr_cnt); end
        checks++; if (data_out0 !== 16'h0) begin errors++; $display("FAIL reset_data_out0: got %h expected 0000", data_out0); end
        checks++; if (data_out1 !== 16'h0) begin errors++; $display("FAIL reset_data_out1: got %h expected 0000", data_out1); end
        rst_n = 1'b1;
    endtask

    task automatic test_two_channels();
        do_reset();
        en = 1'b1; sel = 1'b0; data_in = 16'h1234;
        tick();
        checks++; if (valid0 !== 1'b1 || data_out0 !== 16'h1234) begin errors++; $display("FAIL latency_ch0: got valid=%b data=%h expected valid=1 data=1234", valid0, data_out0); end
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL isolate_ch1: got valid1=%b expected 0", valid1); end
        sel = 1'b1; data_in = 16'hABCD;
        tick();
        en = 1'b0;
        checks++; if (valid0 !== 1'b1 || data_out0 !== 16'h1234) begin errors++; $display("FAIL two_ch_out0: got valid=%b data=%h expected valid=1 data=1234", valid0, data_out0); end
        checks++; if (valid1 !== 1'b1 || data_out1 !== 16'hABCD) begin errors++; $display("FAIL two_ch_out1: got valid=%b data=%h expected valid=1 data=abcd", valid1, data_out1); end
        checks++; if (wr_cnt !== 8'd2) begin errors++; $display("FAIL two_ch_wr_cnt: got %0d expected 2", wr_cnt); end
        ack0 = 1'b1; ack1 = 1'b1;
        tick();
        idle();
        checks++; if (valid0 !== 1'b0 || valid1 !== 1'b0) begin errors++; $display("FAIL dual_pop: got valid0=%b valid1=%b expected 0 0", valid0, valid1); end
    endtask

    task automatic test_overflow();
        do_reset();
        en = 1'b1; sel = 1'b0; data_in = 16'h0001;
        tick();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL ovf_busy_early: got %b expected 0", busy0); end
        data_in = 16'h0002;
        tick();
        checks++; if (busy0 !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL ovf_busy: got busy0=%b err=%b expected 1 0", busy0, err); end
        data_in = 16'h0003;
        tick();
        en = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b expected 1", err); end
        checks++; if (wr_cnt !== 8'd2) begin errors++; $display("FAIL ovf_wr_cnt: got %0d expected 2", wr_cnt); end
        checks++; if (data_out0 !== 16'h0001) begin errors++; $display("FAIL ovf_head: got %h expected 0001", data_out0); end
    endtask

    // Continues from the full channel 0 {1,2} with err=1 left by test_overflow.
    task automatic test_clr_err();
        en = 1'b1; sel = 1'b0; data_in = 16'h0004; clr_err = 1'b1;
        tick();
        checks++; if (err !== 1'b1 || wr_cnt !== 8'd2) begin errors++; $display("FAIL clr_with_drop: got err=%b wr_cnt=%0d expected 1 2", err, wr_cnt); end
        en = 1'b0;
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL clr_alone: got %b expected 0", err); end
        clr_err = 1'b0; en = 1'b1; data_in = 16'h0006; ack0 = 1'b1;
        tick();
        idle();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL full_pop_drop_err: got %b expected 1", err); end
        checks++; if (valid0 !== 1'b1 || busy0 !== 1'b0 || data_out0 !== 16'h0002) begin errors++; $display("FAIL full_pop_drop: got valid=%b busy=%b data=%h expected 1 0 0002", valid0, busy0, data_out0); end
        checks++; if (wr_cnt !== 8'd2) begin errors++; $display("FAIL full_pop_drop_cnt: got %0d expected 2", wr_cnt); end
    endtask

    task automatic test_write_pop();
        do_reset();
        en = 1'b1; sel = 1'b0; data_in = 16'h0001;
        tick();
        data_in = 16'h0005; ack0 = 1'b1;
        tick();
        en = 1'b0;
        checks++; if (valid0 !== 1'b1 || busy0 !== 1'b0 || data_out0 !== 16'h0005) begin errors++; $display("FAIL wr_pop: got valid=%b busy=%b data=%h expected 1 0 0005", valid0, busy0, data_out0); end
        tick();
        ack0 = 1'b0;
        checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL wr_pop_occ1: got valid0=%b expected 0", valid0); end
        ack1 = 1'b1;
        tick();
        idle();
        checks++; if (valid1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL ack_empty: got valid1=%b busy1=%b expected 0 0", valid1, busy1); end
    endtask

    task automatic test_wrap();
        logic [15:0] word;
        do_reset();
        en = 1'b1; sel = 1'b1; ack1 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            word    = 16'(i * 37 + 5);
            data_in = word;
            tick();
            checks++;
            if (valid1 !== 1'b1 || data_out1 !== word) begin
                errors++;
                $display("FAIL stream_%0d: got valid=%b data=%h expected 1 %h", i, valid1, data_out1, word);
            end
        end
        en = 1'b0;
        checks++; if (wr_cnt !== 8'd0) begin errors++; $display("FAIL wrap_wr_cnt: got %0d expected 0", wr_cnt); end
        checks++; if (err !== 1'b0 || valid0 !== 1'b0) begin errors++; $display("FAIL wrap_err: got err=%b valid0=%b expected 0 0", err, valid0); end
        tick();
        idle();
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL wrap_drain: got %b expected 0", valid1); end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1; sel = 1'b1; data_in = 16'h0011;
        tick();
        data_in = 16'h0022;
        tick();
        data_in = 16'h0033;
        tick();
        en = 1'b0;
        checks++; if (busy1 !== 1'b1 || err !== 1'b1 || wr_cnt !== 8'd2) begin errors++; $display("FAIL pre_areset: got busy1=%b err=%b wr_cnt=%0d expected 1 1 2", busy1, err, wr_cnt); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (valid1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL areset_ch1: got valid1=%b busy1=%b expected 0 0", valid1, busy1); end
        checks++; if (err !== 1'b0 || wr_cnt !== 8'd0) begin errors++; $display("FAIL areset_flags: got err=%b wr_cnt=%0d expected 0 0", err, wr_cnt); end
        en = 1'b1; sel = 1'b0; data_in = 16'h0077;
        tick();
        checks++; if (valid0 !== 1'b0 || wr_cnt !== 8'd0) begin errors++; $display("FAIL write_in_reset: got valid0=%b wr_cnt=%0d expected 0 0", valid0, wr_cnt); end
        rst_n = 1'b1;
        tick();
        idle();
        checks++; if (valid0 !== 1'b1 || data_out0 !== 16'h0077 || wr_cnt !== 8'd1) begin errors++; $display("FAIL first_write: got valid=%b data=%h wr_cnt=%0d expected 1 0077 1", valid0, data_out0, wr_cnt); end
    endtask

    initial begin
        test_reset();
        test_two_channels();
        test_overflow();
        test_clr_err();
        test_write_pop();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
